// File: rtl/baudrate_gen_frac.sv
// UART baud-rate generator: integer+fractional divider per channel, RX tick at OVS x baud,
// TX tick at baud, with shadowed runtime configuration and RX phase restart.
module baudrate_gen_frac #(
    parameter int unsigned DIV_W        = 16,
    parameter int unsigned FRAC_W       = 8,
    parameter int unsigned OVS          = 16,
    parameter int unsigned DEF_DIV_INT  = 27,
    parameter int unsigned DEF_DIV_FRAC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_baudrate_tx_clk_en,
    input  logic              I_baudrate_rx_clk_en,
    input  logic              I_rx_restart,
    input  logic              I_cfg_we,
    input  logic [DIV_W-1:0]  I_div_int,
    input  logic [FRAC_W-1:0] I_div_frac,
    output logic              O_baudrate_tx_clk,
    output logic              O_baudrate_rx_clk,
    output logic              O_cfg_pending
);

    localparam int unsigned CNT_W = DIV_W + 1;
    localparam int unsigned OVS_W = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int unsigned CH_TX = 0;
    localparam int unsigned CH_RX = 1;

    logic [1:0]                    run_q, run_d;
    logic [1:0]                    base_q, base_d;
    logic [1:0]                    upd_q, upd_d;
    logic [1:0][CNT_W-1:0]         cnt_q, cnt_d;
    logic [1:0][FRAC_W-1:0]        acc_q, acc_d;
    logic [1:0][DIV_W-1:0]         act_int_q, act_int_d;
    logic [1:0][FRAC_W-1:0]        act_frac_q, act_frac_d;
    logic [DIV_W-1:0]              shd_int_q, shd_int_d;
    logic [FRAC_W-1:0]             shd_frac_q, shd_frac_d;
    logic [OVS_W-1:0]              ovs_q, ovs_d;
    logic                          tx_q, tx_d;
    logic                          pend_q, pend_d;
    logic [1:0]                    en;

    assign en = {I_baudrate_rx_clk_en, I_baudrate_tx_clk_en};

    // Reload value D-1+carry, with divisors below 2 clamped to 2.
    function automatic logic [CNT_W-1:0] reload_val(input logic [DIV_W-1:0] div, input logic carry);
        logic [CNT_W-1:0] d;
        d = (div < DIV_W'(2)) ? CNT_W'(2) : {1'b0, div};
        return d - CNT_W'(1) + CNT_W'(carry);
    endfunction

    always_comb begin
        run_d      = run_q;
        base_d     = '0;
        upd_d      = upd_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        shd_int_d  = I_cfg_we ? I_div_int  : shd_int_q;
        shd_frac_d = I_cfg_we ? I_div_frac : shd_frac_q;
        ovs_d      = ovs_q;
        tx_d       = 1'b0;

        for (int c = 0; c < 2; c++) begin
            logic [DIV_W-1:0] src_int;
            logic [FRAC_W:0]  sum;
            logic             load;
            logic             apply;
            apply   = 1'b0;
            src_int = upd_q[c] ? shd_int_q : act_int_q[c];
            load    = !run_q[c] || ((c == int'(CH_RX)) && I_rx_restart);
            sum     = {1'b0, acc_q[c]} + {1'b0, act_frac_q[c]};

            if (!en[c]) begin
                run_d[c] = 1'b0;
                cnt_d[c] = '0;
                acc_d[c] = '0;
                apply    = upd_q[c];
            end else if (load) begin
                run_d[c] = 1'b1;
                cnt_d[c] = reload_val(src_int, 1'b0);
                acc_d[c] = '0;
                apply    = upd_q[c];
            end else if (cnt_q[c] != '0) begin
                cnt_d[c] = cnt_q[c] - CNT_W'(1);
            end else begin
                base_d[c] = 1'b1;
                if (upd_q[c]) begin
                    cnt_d[c] = reload_val(shd_int_q, 1'b0);
                    acc_d[c] = '0;
                    apply    = 1'b1;
                end else begin
                    cnt_d[c] = reload_val(act_int_q[c], sum[FRAC_W]);
                    acc_d[c] = sum[FRAC_W-1:0];
                end
            end

            if (apply) begin
                act_int_d[c]  = shd_int_q;
                act_frac_d[c] = shd_frac_q;
                upd_d[c]      = 1'b0;
            end
            // A new write invalidates any earlier apply, so both channels take it again.
            if (I_cfg_we) begin
                upd_d[c] = 1'b1;
            end
        end

        if (!I_baudrate_tx_clk_en) begin
            ovs_d = '0;
        end else if (base_d[CH_TX]) begin
            if (ovs_q == OVS_W'(OVS - 1)) begin
                tx_d  = 1'b1;
                ovs_d = '0;
            end else begin
                ovs_d = ovs_q + OVS_W'(1);
            end
        end

        pend_d = |upd_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q      <= '0;
            base_q     <= '0;
            upd_q      <= '0;
            cnt_q      <= '0;
            acc_q      <= '0;
            act_int_q  <= {DIV_W'(DEF_DIV_INT), DIV_W'(DEF_DIV_INT)};
            act_frac_q <= {FRAC_W'(DEF_DIV_FRAC), FRAC_W'(DEF_DIV_FRAC)};
            shd_int_q  <= DIV_W'(DEF_DIV_INT);
            shd_frac_q <= FRAC_W'(DEF_DIV_FRAC);
            ovs_q      <= '0;
            tx_q       <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            run_q      <= run_d;
            base_q     <= base_d;
            upd_q      <= upd_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            shd_int_q  <= shd_int_d;
            shd_frac_q <= shd_frac_d;
            ovs_q      <= ovs_d;
            tx_q       <= tx_d;
            pend_q     <= pend_d;
        end
    end

    assign O_baudrate_tx_clk = tx_q;
    assign O_baudrate_rx_clk = base_q[CH_RX];
    assign O_cfg_pending     = pend_q;

endmodule

// File: tb/tb_baudrate_gen_frac.sv
// Directed-vector bench for baudrate_gen_frac with default parameters (DIV_W=16, FRAC_W=8, OVS=16).
module tb_baudrate_gen_frac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tx_en = 1'b0;
    logic        rx_en = 1'b0;
    logic        rx_restart = 1'b0;
    logic        cfg_we = 1'b0;
    logic [15:0] div_int = 16'd0;
    logic [7:0]  div_frac = 8'd0;
    logic        tx_clk;
    logic        rx_clk;
    logic        cfg_pending;

    int tests = 0;
    int fails = 0;

    baudrate_gen_frac dut (
        .clk                  (clk),
        .rst                  (rst),
        .I_baudrate_tx_clk_en (tx_en),
        .I_baudrate_rx_clk_en (rx_en),
        .I_rx_restart         (rx_restart),
        .I_cfg_we             (cfg_we),
        .I_div_int            (div_int),
        .I_div_frac           (div_frac),
        .O_baudrate_tx_clk    (tx_clk),
        .O_baudrate_rx_clk    (rx_clk),
        .O_cfg_pending        (cfg_pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until an RX tick or the budget runs out; returns cycles taken (max+1 on timeout).
    task automatic wait_rx(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (rx_clk !== 1'b1 && n <= max);
    endtask

    task automatic configure(input logic [15:0] di, input logic [7:0] df);
        tx_en = 1'b0;
        rx_en = 1'b0;
        step();
        cfg_we   = 1'b1;
        div_int  = di;
        div_frac = df;
        step();
        cfg_we = 1'b0;
        step();
    endtask

    task automatic test_reset();
        tests++;
        if (tx_clk !== 1'b0) begin fails++; $display("FAIL reset_tx: got %b expected 0", tx_clk); end
        tests++;
        if (rx_clk !== 1'b0) begin fails++; $display("FAIL reset_rx: got %b expected 0", rx_clk); end
        tests++;
        if (cfg_pending !== 1'b0) begin fails++; $display("FAIL reset_pending: got %b expected 0", cfg_pending); end
    endtask

    task automatic test_basic();
        int rx_cnt, rx_bad, tx_cnt, tx_t1, tx_t2;
        rx_cnt = 0; rx_bad = 0; tx_cnt = 0; tx_t1 = 0; tx_t2 = 0;
        cfg_we  = 1'b1;
        div_int = 16'd4;
        div_frac = 8'd0;
        step();
        cfg_we = 1'b0;
        tests++;
        if (cfg_pending !== 1'b1) begin fails++; $display("FAIL basic_pend_set: got %b expected 1", cfg_pending); end
        step();
        tests++;
        if (cfg_pending !== 1'b0) begin fails++; $display("FAIL basic_pend_clr: got %b expected 0", cfg_pending); end
        tx_en = 1'b1;
        rx_en = 1'b1;
        step();
        for (int k = 1; k <= 130; k++) begin
            step();
            if (rx_clk === 1'b1) begin
                rx_cnt++;
                if (k % 4 != 0) rx_bad++;
            end
            if (tx_clk === 1'b1) begin
                tx_cnt++;
                if (tx_cnt == 1) tx_t1 = k;
                else if (tx_cnt == 2) tx_t2 = k;
            end
        end
        tests++;
        if (rx_bad != 0) begin fails++; $display("FAIL basic_rx_phase: got %0d off-grid ticks expected 0", rx_bad); end
        tests++;
        if (rx_cnt != 32) begin fails++; $display("FAIL basic_rx_count: got %0d expected 32", rx_cnt); end
        tests++;
        if (tx_cnt != 2) begin fails++; $display("FAIL basic_tx_count: got %0d expected 2", tx_cnt); end
        tests++;
        if (tx_t1 != 64) begin fails++; $display("FAIL basic_tx_first: got %0d expected 64", tx_t1); end
        tests++;
        if (tx_t2 != 128) begin fails++; $display("FAIL basic_tx_second: got %0d expected 128", tx_t2); end
    endtask

    task automatic test_frac();
        int t[5];
        int exp_t[5];
        int cnt;
        logic at_end;
        exp_t = '{3, 6, 10, 13, 17};
        t = '{0, 0, 0, 0, 0};
        cnt = 0;
        at_end = 1'b0;
        configure(16'd3, 8'd128);
        rx_en = 1'b1;
        step();
        for (int k = 1; k <= 899; k++) begin
            step();
            if (rx_clk === 1'b1) begin
                if (cnt < 5) t[cnt] = k;
                cnt++;
                if (k == 899) at_end = 1'b1;
            end
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (t[i] != exp_t[i]) begin fails++; $display("FAIL frac_tick%0d: got %0d expected %0d", i, t[i], exp_t[i]); end
        end
        tests++;
        if (cnt != 257) begin fails++; $display("FAIL frac_count: got %0d expected 257", cnt); end
        tests++;
        if (at_end !== 1'b1) begin fails++; $display("FAIL frac_span: got %b expected tick at 899", at_end); end
    endtask

    task automatic test_clamp();
        int n;
        for (int v = 1; v >= 0; v--) begin
            configure(16'(v), 8'd0);
            rx_en = 1'b1;
            step();
            for (int i = 0; i < 3; i++) begin
                wait_rx(10, n);
                tests++;
                if (n != 2) begin fails++; $display("FAIL clamp_div%0d_int%0d: got %0d expected 2", v, i, n); end
            end
        end
    endtask

    task automatic test_restart();
        int tx_cnt, tx_t1;
        tx_cnt = 0; tx_t1 = 0;
        configure(16'd10, 8'd0);
        tx_en = 1'b1;
        rx_en = 1'b1;
        step();
        for (int k = 1; k <= 165; k++) begin
            step();
            if (k == 16) rx_restart = 1'b1;
            if (k == 17) rx_restart = 1'b0;
            if (k == 10 || k == 27 || k == 37) begin
                tests++;
                if (rx_clk !== 1'b1) begin fails++; $display("FAIL restart_rx_at%0d: got %b expected 1", k, rx_clk); end
            end
            if (k == 20) begin
                tests++;
                if (rx_clk !== 1'b0) begin fails++; $display("FAIL restart_old_phase: got %b expected 0", rx_clk); end
            end
            if (tx_clk === 1'b1) begin
                tx_cnt++;
                if (tx_cnt == 1) tx_t1 = k;
            end
        end
        tests++;
        if (tx_t1 != 160) begin fails++; $display("FAIL restart_tx_first: got %0d expected 160", tx_t1); end
        tests++;
        if (tx_cnt != 1) begin fails++; $display("FAIL restart_tx_count: got %0d expected 1", tx_cnt); end
    endtask

    task automatic test_cfg_live();
        int t[6];
        int exp_t[6];
        int cnt, pend_cycles;
        logic pend23;
        exp_t = '{8, 16, 24, 29, 34, 39};
        t = '{0, 0, 0, 0, 0, 0};
        cnt = 0; pend_cycles = 0; pend23 = 1'b0;
        configure(16'd8, 8'd0);
        rx_en = 1'b1;
        step();
        for (int k = 1; k <= 40; k++) begin
            step();
            if (k == 22) begin cfg_we = 1'b1; div_int = 16'd5; end
            if (k == 23) cfg_we = 1'b0;
            if (cfg_pending === 1'b1) pend_cycles++;
            if (k == 23) pend23 = cfg_pending;
            if (rx_clk === 1'b1) begin
                if (cnt < 6) t[cnt] = k;
                cnt++;
            end
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (t[i] != exp_t[i]) begin fails++; $display("FAIL live_tick%0d: got %0d expected %0d", i, t[i], exp_t[i]); end
        end
        tests++;
        if (pend_cycles != 1) begin fails++; $display("FAIL live_pend_len: got %0d expected 1", pend_cycles); end
        tests++;
        if (pend23 !== 1'b1) begin fails++; $display("FAIL live_pend_at23: got %b expected 1", pend23); end
    endtask

    task automatic test_async_reset();
        int n;
        configure(16'd5, 8'd0);
        rx_en = 1'b1;
        tx_en = 1'b1;
        step();
        wait_rx(10, n);
        tests++;
        if (rx_clk !== 1'b1) begin fails++; $display("FAIL areset_pre_tick: got %b expected 1", rx_clk); end
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if (rx_clk !== 1'b0) begin fails++; $display("FAIL areset_rx_now: got %b expected 0", rx_clk); end
        tests++;
        if (tx_clk !== 1'b0) begin fails++; $display("FAIL areset_tx_now: got %b expected 0", tx_clk); end
        rx_en = 1'b0;
        tx_en = 1'b0;
        step();
        step();
        #3;
        rst = 1'b0;
        step();
        tests++;
        if (cfg_pending !== 1'b0) begin fails++; $display("FAIL areset_pending: got %b expected 0", cfg_pending); end
        rx_en = 1'b1;
        step();
        wait_rx(40, n);
        tests++;
        if (n != 27) begin fails++; $display("FAIL areset_first_tick: got %0d expected 27", n); end
    endtask

    initial begin
        #13;
        rst = 1'b0;
        step();
        test_reset();
        test_basic();
        test_frac();
        test_clamp();
        test_restart();
        test_cfg_live();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
